// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt-acknowledge sequencer and its ISR/EOI block.
// Optional AEOI_EN adds the OCW2 rotate-in-AEOI codes, which are used only in that build.
package pic_pkg;

  localparam int unsigned LVL_W  = 3;
  localparam int unsigned NUM_IR = 8;
  localparam int unsigned VB_W   = 5;

  localparam logic [LVL_W-1:0] SPURIOUS_LEVEL = 3'd7;

  // OCW2 {R,SL,EOI} encodings
  localparam logic [2:0] EOI_NONSPEC     = 3'b001;
  localparam logic [2:0] EOI_SPEC        = 3'b011;
  localparam logic [2:0] EOI_ROT_NONSPEC = 3'b101;
  localparam logic [2:0] EOI_ROT_SPEC    = 3'b111;
  localparam logic [2:0] SET_PRIO        = 3'b110;
  localparam logic [2:0] ROT_AEOI_SET    = 3'b100;
  localparam logic [2:0] ROT_AEOI_CLR    = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK1,
    ST_GAP,
    ST_ACK2
  } state_t;

  // Highest-priority set bit, scanning upward from ls+1; returns {found, level}
  function automatic logic [LVL_W:0] ns_pick(input logic [NUM_IR-1:0] v,
                                             input logic [LVL_W-1:0] ls);
    logic [LVL_W:0]   r;
    logic [LVL_W-1:0] idx;
    r = '0;
    for (int i = 8; i >= 1; i--) begin
      idx = ls + 3'(i);
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_isr_eoi.sv
// In-service register with ACK set, OCW2 EOI clears, AEOI clear and rotation pointer.
module pic_isr_eoi
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [LVL_W-1:0]  set_level,
  input  logic              eoi_valid,
  input  logic [2:0]        eoi_cmd,
  input  logic [LVL_W-1:0]  eoi_level,
  input  logic              aeoi_clr,
  input  logic              aeoi_rot,
  input  logic [LVL_W-1:0]  aeoi_level,
  output logic [NUM_IR-1:0] isr,
  output logic [LVL_W-1:0]  last_serviced
);

  logic [LVL_W:0]      pick_c;
  logic [NUM_IR-1:0]   clr_c;
  logic [NUM_IR-1:0]   set_c;
  logic [NUM_IR-1:0]   isr_n;
  logic [LVL_W-1:0]    ls_n;

  always_comb begin
    pick_c = ns_pick(isr, last_serviced);
    clr_c  = '0;
    ls_n   = last_serviced;
    if (aeoi_clr) begin
      clr_c[aeoi_level] = 1'b1;
      if (aeoi_rot) ls_n = aeoi_level;
    end
    if (eoi_valid) begin
      case (eoi_cmd)
        EOI_NONSPEC: if (pick_c[LVL_W]) clr_c[pick_c[LVL_W-1:0]] = 1'b1;
        EOI_ROT_NONSPEC: begin
          if (pick_c[LVL_W]) begin
            clr_c[pick_c[LVL_W-1:0]] = 1'b1;
            ls_n = pick_c[LVL_W-1:0];
          end
        end
        EOI_SPEC: clr_c[eoi_level] = 1'b1;
        EOI_ROT_SPEC: begin
          clr_c[eoi_level] = 1'b1;
          ls_n = eoi_level;
        end
        SET_PRIO: ls_n = eoi_level;
        default: ;
      endcase
    end
    set_c = set_en ? (8'b1 << set_level) : '0;
    // a set landing on a bit being cleared in the same cycle wins
    isr_n = (isr & ~clr_c) | set_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      isr           <= '0;
      last_serviced <= SPURIOUS_LEVEL;
    end else begin
      isr           <= isr_n;
      last_serviced <= ls_n;
    end
  end

endmodule

// File: rtl/inta_sequencer.sv
// 8259-style INTA sequencer: raises INT, runs the two-pulse acknowledge and drives the vector.
// Define AEOI_EN to add the aeoi_mode input (automatic EOI on the second INTA rising edge).
module inta_sequencer
  import pic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              int_flag,
  input  logic [LVL_W-1:0]  priority_id,
  input  logic              inta_n,
  input  logic [VB_W-1:0]   vector_base,
  input  logic              eoi_valid,
  input  logic [2:0]        eoi_cmd,
  input  logic [LVL_W-1:0]  eoi_level,
`ifdef AEOI_EN
  input  logic              aeoi_mode,
`endif
  output logic              int_out,
  output logic [NUM_IR-1:0] isr,
  output logic [LVL_W-1:0]  last_serviced,
  output logic [NUM_IR-1:0] irr_clear,
  output logic [7:0]        data_out,
  output logic              data_oe
);

  state_t             state, state_n;
  logic               inta_n_d;
  logic               fall_c, rise_c;
  logic [LVL_W-1:0]   level, level_n;
  logic               spurious, spurious_n;
  logic               set_pend, set_pend_n;
  logic               int_out_n;
  logic [NUM_IR-1:0]  irr_clear_n;
  logic [7:0]         data_out_n;
  logic               data_oe_n;
  logic               aeoi_clr_c;
  logic               aeoi_rot_c;

  assign fall_c = !inta_n && inta_n_d;
  assign rise_c = inta_n && !inta_n_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      inta_n_d  <= 1'b1;
      level     <= SPURIOUS_LEVEL;
      spurious  <= 1'b0;
      set_pend  <= 1'b0;
      int_out   <= 1'b0;
      irr_clear <= '0;
      data_out  <= '0;
      data_oe   <= 1'b0;
    end else begin
      state     <= state_n;
      inta_n_d  <= inta_n;
      level     <= level_n;
      spurious  <= spurious_n;
      set_pend  <= set_pend_n;
      int_out   <= int_out_n;
      irr_clear <= irr_clear_n;
      data_out  <= data_out_n;
      data_oe   <= data_oe_n;
    end
  end

  always_comb begin
    state_n     = state;
    level_n     = level;
    spurious_n  = spurious;
    set_pend_n  = 1'b0;
    irr_clear_n = '0;
    case (state)
      ST_IDLE: if (int_flag) state_n = ST_REQ;
      ST_REQ: begin
        // a request withdrawn before the first INTA resolves as spurious level 7
        if (fall_c) begin
          state_n = ST_ACK1;
          if (int_flag) begin
            level_n     = priority_id;
            spurious_n  = 1'b0;
            irr_clear_n = 8'b1 << priority_id;
            set_pend_n  = 1'b1;
          end else begin
            level_n    = SPURIOUS_LEVEL;
            spurious_n = 1'b1;
          end
        end
      end
      ST_ACK1: if (rise_c) state_n = ST_GAP;
      ST_GAP:  if (fall_c) state_n = ST_ACK2;
      ST_ACK2: if (rise_c) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    int_out_n  = (state_n == ST_REQ);
    data_oe_n  = (state_n == ST_ACK2);
    data_out_n = data_oe_n ? {vector_base, level_n} : 8'h00;
  end

`ifdef AEOI_EN
  logic rot_aeoi, rot_aeoi_n;

  always_comb begin
    rot_aeoi_n = rot_aeoi;
    if (eoi_valid && eoi_cmd == ROT_AEOI_SET)      rot_aeoi_n = 1'b1;
    else if (eoi_valid && eoi_cmd == ROT_AEOI_CLR) rot_aeoi_n = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) rot_aeoi <= 1'b0;
    else     rot_aeoi <= rot_aeoi_n;
  end

  assign aeoi_clr_c = aeoi_mode && !spurious && (state == ST_ACK2) && rise_c;
  assign aeoi_rot_c = aeoi_clr_c && rot_aeoi;
`else
  assign aeoi_clr_c = 1'b0;
  assign aeoi_rot_c = 1'b0;
`endif

  pic_isr_eoi u_isr_eoi (
    .clk           (clk),
    .rst           (rst),
    .set_en        (set_pend),
    .set_level     (level),
    .eoi_valid     (eoi_valid),
    .eoi_cmd       (eoi_cmd),
    .eoi_level     (eoi_level),
    .aeoi_clr      (aeoi_clr_c),
    .aeoi_rot      (aeoi_rot_c),
    .aeoi_level    (level),
    .isr           (isr),
    .last_serviced (last_serviced)
  );

endmodule

// File: tb/tb_inta_sequencer.sv
// Randomized self-checking bench for inta_sequencer against a behavioural ISR/vector model.
// Build with AEOI_EN defined to also exercise the automatic-EOI path.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst, int_flag, inta_n, eoi_valid;
  logic [2:0] priority_id, eoi_cmd, eoi_level;
  logic [4:0] vector_base;
  logic       int_out, data_oe;
  logic [7:0] isr, irr_clear, data_out;
  logic [2:0] last_serviced;
`ifdef AEOI_EN
  logic       aeoi_mode;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_isr;
  logic [2:0] m_ls;

  logic       obs_int_seen, obs_int_held, obs_int_after, obs_stable, obs_oe_after;
  logic [7:0] obs_irr_or, obs_isr_mid, obs_isr_end, obs_dout;
  int         obs_irr_cnt, obs_oe_cnt;

  inta_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .int_flag      (int_flag),
    .priority_id   (priority_id),
    .inta_n        (inta_n),
    .vector_base   (vector_base),
    .eoi_valid     (eoi_valid),
    .eoi_cmd       (eoi_cmd),
    .eoi_level     (eoi_level),
`ifdef AEOI_EN
    .aeoi_mode     (aeoi_mode),
`endif
    .int_out       (int_out),
    .isr           (isr),
    .last_serviced (last_serviced),
    .irr_clear     (irr_clear),
    .data_out      (data_out),
    .data_oe       (data_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_irr();
    if (irr_clear != 8'h00) begin
      obs_irr_cnt++;
      obs_irr_or = obs_irr_or | irr_clear;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1; int_flag = 1'b0; inta_n = 1'b1; eoi_valid = 1'b0;
    eoi_cmd = 3'd0; eoi_level = 3'd0; priority_id = 3'd0; vector_base = 5'd0;
`ifdef AEOI_EN
    aeoi_mode = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    m_isr = 8'h00;
    m_ls  = 3'd7;
  endtask

  // Full request + two-pulse acknowledge; records what the DUT shows along the way
  task automatic run_ack(input logic drop, input logic [2:0] pid, input logic [4:0] vb,
                         input int p1, input int gap, input int p2);
    obs_irr_or = 8'h00; obs_irr_cnt = 0; obs_oe_cnt = 0; obs_stable = 1'b1;
    int_flag = 1'b1; priority_id = pid; vector_base = vb;
    tick;
    obs_int_seen = int_out;
    repeat ($urandom_range(2)) tick;
    if (drop) begin
      int_flag = 1'b0;
      repeat (1 + $urandom_range(2)) tick;
    end
    obs_int_held = int_out;
    inta_n = 1'b0;
    tick;
    obs_int_after = int_out;
    int_flag = 1'b0;
    sample_irr();
    for (int i = 1; i < p1; i++) begin tick; sample_irr(); end
    inta_n = 1'b1;
    tick; sample_irr();
    repeat (gap) begin tick; sample_irr(); end
    obs_isr_mid = isr;
    inta_n = 1'b0;
    tick;
    obs_dout = data_out;
    if (data_oe === 1'b1) obs_oe_cnt++;
    for (int i = 1; i < p2; i++) begin
      tick;
      if (data_oe === 1'b1) obs_oe_cnt++;
      if (data_out !== obs_dout) obs_stable = 1'b0;
    end
    inta_n = 1'b1;
    tick;
    obs_oe_after = data_oe;
    obs_isr_end  = isr;
    tick;
  endtask

  task automatic issue_eoi(input logic [2:0] cmd, input logic [2:0] lvl);
    eoi_valid = 1'b1; eoi_cmd = cmd; eoi_level = lvl;
    tick;
    eoi_valid = 1'b0;
  endtask

  // Reference: clear/rotate rules written directly from the OCW2 command meanings
  task automatic model_eoi(input logic [2:0] cmd, input logic [2:0] lvl);
    logic       found;
    logic [2:0] hit, idx;
    found = 1'b0; hit = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = 3'((int'(m_ls) + k) % 8);
      if (!found && m_isr[idx]) begin found = 1'b1; hit = idx; end
    end
    case (cmd)
      3'b001: if (found) m_isr[hit] = 1'b0;
      3'b011: m_isr[lvl] = 1'b0;
      3'b101: if (found) begin m_isr[hit] = 1'b0; m_ls = hit; end
      3'b111: begin m_isr[lvl] = 1'b0; m_ls = lvl; end
      3'b110: m_ls = lvl;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    reset_dut();
    n_tests++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL reset_int_out got=%b exp=0", int_out); end
    n_tests++; if (isr !== 8'h00) begin n_fail++; $display("FAIL reset_isr got=%h exp=00", isr); end
    n_tests++; if (irr_clear !== 8'h00) begin n_fail++; $display("FAIL reset_irr_clear got=%h exp=00", irr_clear); end
    n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    n_tests++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got=%b exp=0", data_oe); end
    n_tests++; if (last_serviced !== 3'd7) begin n_fail++; $display("FAIL reset_last_serviced got=%0d exp=7", last_serviced); end
  endtask

  task automatic test_basic();
    reset_dut();
    run_ack(1'b0, 3'd3, 5'h08, 1, 1, 1);
    n_tests++; if (obs_int_seen !== 1'b1) begin n_fail++; $display("FAIL basic_int_out got=%b exp=1", obs_int_seen); end
    n_tests++; if (obs_int_after !== 1'b0) begin n_fail++; $display("FAIL basic_int_drop got=%b exp=0", obs_int_after); end
    n_tests++; if (obs_irr_or !== 8'h08) begin n_fail++; $display("FAIL basic_irr_clear got=%h exp=08", obs_irr_or); end
    n_tests++; if (obs_irr_cnt !== 1) begin n_fail++; $display("FAIL basic_irr_cycles got=%0d exp=1", obs_irr_cnt); end
    n_tests++; if (obs_isr_mid !== 8'h08) begin n_fail++; $display("FAIL basic_isr got=%h exp=08", obs_isr_mid); end
    n_tests++; if (obs_dout !== 8'h43) begin n_fail++; $display("FAIL basic_vector got=%h exp=43", obs_dout); end
    n_tests++; if (obs_oe_cnt !== 1) begin n_fail++; $display("FAIL basic_oe_cycles got=%0d exp=1", obs_oe_cnt); end
    n_tests++; if (obs_oe_after !== 1'b0) begin n_fail++; $display("FAIL basic_oe_release got=%b exp=0", obs_oe_after); end
    m_isr[3] = 1'b1;
  endtask

  task automatic test_spurious();
    logic [4:0] vb;
    logic [7:0] exp_v;
    vb = 5'($urandom_range(31));
    exp_v = 8'(int'(vb) * 8 + 7);
    run_ack(1'b1, 3'($urandom_range(6)), vb, 2, 1, 2);
    n_tests++; if (obs_int_held !== 1'b1) begin n_fail++; $display("FAIL spur_int_held got=%b exp=1", obs_int_held); end
    n_tests++; if (obs_irr_or !== 8'h00) begin n_fail++; $display("FAIL spur_irr_clear got=%h exp=00", obs_irr_or); end
    n_tests++; if (obs_isr_end !== m_isr) begin n_fail++; $display("FAIL spur_isr got=%h exp=%h", obs_isr_end, m_isr); end
    n_tests++; if (obs_dout !== exp_v) begin n_fail++; $display("FAIL spur_vector got=%h exp=%h", obs_dout, exp_v); end
  endtask

  task automatic test_random_acks();
    logic       drop;
    logic [2:0] pid;
    logic [4:0] vb;
    logic [7:0] exp_irr, exp_v;
    int         p1, gap, p2;
    for (int n = 0; n < 6; n++) begin
      drop = ($urandom_range(3) == 0);
      pid  = 3'($urandom_range(7));
      vb   = 5'($urandom_range(31));
      p1 = 1 + $urandom_range(2); gap = 1 + $urandom_range(2); p2 = 1 + $urandom_range(2);
      run_ack(drop, pid, vb, p1, gap, p2);
      exp_irr = drop ? 8'h00 : 8'(1 << pid);
      exp_v   = 8'(int'(vb) * 8 + (drop ? 7 : int'(pid)));
      if (!drop) m_isr[pid] = 1'b1;
      n_tests++; if (obs_irr_or !== exp_irr) begin n_fail++; $display("FAIL rand_irr[%0d] got=%h exp=%h", n, obs_irr_or, exp_irr); end
      n_tests++; if (obs_dout !== exp_v || !obs_stable) begin n_fail++; $display("FAIL rand_vector[%0d] got=%h exp=%h", n, obs_dout, exp_v); end
      n_tests++; if (obs_oe_cnt !== p2) begin n_fail++; $display("FAIL rand_oe_cycles[%0d] got=%0d exp=%0d", n, obs_oe_cnt, p2); end
      n_tests++; if (obs_isr_end !== m_isr) begin n_fail++; $display("FAIL rand_isr[%0d] got=%h exp=%h", n, obs_isr_end, m_isr); end
    end
  endtask

  task automatic test_eoi_directed();
    reset_dut();
    run_ack(1'b0, 3'd2, 5'h01, 1, 1, 1);
    run_ack(1'b0, 3'd5, 5'h01, 1, 1, 1);
    n_tests++; if (isr !== 8'h24) begin n_fail++; $display("FAIL eoi_setup got=%h exp=24", isr); end
    issue_eoi(3'b001, 3'd0);
    n_tests++; if (isr !== 8'h20) begin n_fail++; $display("FAIL eoi_nonspec got=%h exp=20", isr); end
    run_ack(1'b0, 3'd2, 5'h01, 1, 1, 1);
    issue_eoi(3'b110, 3'd2);
    n_tests++; if (last_serviced !== 3'd2) begin n_fail++; $display("FAIL eoi_setprio got=%0d exp=2", last_serviced); end
    issue_eoi(3'b101, 3'd0);
    n_tests++; if (isr !== 8'h04) begin n_fail++; $display("FAIL eoi_rot_isr got=%h exp=04", isr); end
    n_tests++; if (last_serviced !== 3'd5) begin n_fail++; $display("FAIL eoi_rot_ls got=%0d exp=5", last_serviced); end
    m_isr = 8'h04; m_ls = 3'd5;
  endtask

  task automatic test_eoi_random();
    logic [2:0] cmd, lvl, pid;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(1) == 1) begin
        pid = 3'($urandom_range(7));
        run_ack(1'b0, pid, 5'h10, 1, 1, 1);
        m_isr[pid] = 1'b1;
      end
      cmd = 3'($urandom_range(7));
      lvl = 3'($urandom_range(7));
      issue_eoi(cmd, lvl);
      model_eoi(cmd, lvl);
      n_tests++; if (isr !== m_isr || last_serviced !== m_ls)
        begin n_fail++; $display("FAIL eoi_rand[%0d] cmd=%b got=%h/%0d exp=%h/%0d", n, cmd, isr, last_serviced, m_isr, m_ls); end
    end
  endtask

  // ACK set presented in the same cycle as a specific EOI
  task automatic collide(input logic [2:0] pid, input logic [2:0] lvl);
    int_flag = 1'b1; priority_id = pid; vector_base = 5'h02;
    tick;
    inta_n = 1'b0;
    tick;
    obs_irr_or = irr_clear;
    int_flag = 1'b0;
    eoi_valid = 1'b1; eoi_cmd = 3'b011; eoi_level = lvl;
    tick;
    eoi_valid = 1'b0;
    obs_isr_mid = isr;
    inta_n = 1'b1; tick;
    inta_n = 1'b0; tick;
    inta_n = 1'b1; tick;
    tick;
  endtask

  task automatic test_collision();
    reset_dut();
    run_ack(1'b0, 3'd4, 5'h02, 1, 1, 1);
    collide(3'd1, 3'd4);
    n_tests++; if (obs_irr_or !== 8'h02) begin n_fail++; $display("FAIL coll_irr got=%h exp=02", obs_irr_or); end
    n_tests++; if (obs_isr_mid !== 8'h02) begin n_fail++; $display("FAIL coll_other got=%h exp=02", obs_isr_mid); end
    collide(3'd1, 3'd1);
    n_tests++; if (obs_isr_mid !== 8'h02) begin n_fail++; $display("FAIL coll_same got=%h exp=02", obs_isr_mid); end
    m_isr = 8'h02;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    run_ack(1'b0, 3'd2, 5'h03, 1, 1, 1);
    issue_eoi(3'b110, 3'd3);
    int_flag = 1'b1; priority_id = 3'd5; vector_base = 5'h03;
    tick;
    inta_n = 1'b0; tick;
    int_flag = 1'b0;
    inta_n = 1'b1; tick;
    rst = 1'b1; tick;
    n_tests++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_int_out got=%b exp=0", int_out); end
    n_tests++; if (isr !== 8'h00) begin n_fail++; $display("FAIL rstmid_isr got=%h exp=00", isr); end
    n_tests++; if (last_serviced !== 3'd7) begin n_fail++; $display("FAIL rstmid_ls got=%0d exp=7", last_serviced); end
    n_tests++; if (data_oe !== 1'b0 || irr_clear !== 8'h00) begin n_fail++; $display("FAIL rstmid_oe_irr got=%b/%h exp=0/00", data_oe, irr_clear); end
    rst = 1'b0;
    inta_n = 1'b0; tick;
    n_tests++; if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_ack2 got=%b exp=0", data_oe); end
    inta_n = 1'b1; tick;
    m_isr = 8'h00; m_ls = 3'd7;
  endtask

  task automatic test_idle_edges();
    logic [5:0] pat;
    logic [7:0] exp_v;
    pat = 6'b110100;
    int_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      inta_n = pat[i];
      tick;
      n_tests++; if (int_out !== 1'b0 || data_oe !== 1'b0 || irr_clear !== 8'h00 || isr !== m_isr)
        begin n_fail++; $display("FAIL idle_edge[%0d] got=%b%b/%h/%h exp=00/00/%h", i, int_out, data_oe, irr_clear, isr, m_isr); end
    end
    inta_n = 1'b1; tick;
    run_ack(1'b0, 3'd6, 5'h1f, 1, 2, 1);
    m_isr[6] = 1'b1;
    exp_v = 8'(31 * 8 + 6);
    n_tests++; if (obs_dout !== exp_v) begin n_fail++; $display("FAIL idle_then_ack got=%h exp=%h", obs_dout, exp_v); end
  endtask

`ifdef AEOI_EN
  task automatic test_aeoi();
    reset_dut();
    aeoi_mode = 1'b1;
    run_ack(1'b0, 3'd6, 5'h04, 1, 1, 2);
    n_tests++; if (obs_isr_mid !== 8'h40) begin n_fail++; $display("FAIL aeoi_set got=%h exp=40", obs_isr_mid); end
    n_tests++; if (obs_isr_end !== 8'h00) begin n_fail++; $display("FAIL aeoi_clear got=%h exp=00", obs_isr_end); end
    n_tests++; if (last_serviced !== 3'd7) begin n_fail++; $display("FAIL aeoi_no_rot got=%0d exp=7", last_serviced); end
    issue_eoi(3'b100, 3'd0);
    run_ack(1'b0, 3'd6, 5'h04, 1, 1, 1);
    n_tests++; if (obs_isr_end !== 8'h00 || last_serviced !== 3'd6)
      begin n_fail++; $display("FAIL aeoi_rot got=%h/%0d exp=00/6", obs_isr_end, last_serviced); end
    aeoi_mode = 1'b0;
    reset_dut();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_spurious();
    test_random_acks();
    test_eoi_directed();
    test_eoi_random();
    test_collision();
    test_reset_mid();
    test_idle_edges();
`ifdef AEOI_EN
    test_aeoi();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
